// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks up to CDB_WIDTH finished results per cycle
// (starving requesters first, then round-robin) and broadcasts them one cycle later.
module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CDB_WIDTH    = 2,
  parameter int XLEN         = 32,
  parameter int PRF_IDX_W    = 6,
  parameter int ROB_IDX_W    = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][PRF_IDX_W-1:0]    req_prf_idx,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]    req_rob_idx,
  input  logic [NUM_REQ-1:0][XLEN-1:0]         req_value,
  input  logic [NUM_REQ-1:0]                   req_reg_write,
  output logic [NUM_REQ-1:0]                   grant,
  output logic [NUM_REQ-1:0]                   CDB_hazard,
  output logic [CDB_WIDTH-1:0]                 cdb_valid,
  output logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0]  cdb_prf_idx,
  output logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0]  cdb_rob_idx,
  output logic [CDB_WIDTH-1:0][XLEN-1:0]       cdb_value,
  output logic [CDB_WIDTH-1:0]                 cdb_reg_write
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [PTR_W-1:0]                       rr_ptr;
  logic [NUM_REQ-1:0][CNT_W-1:0]          wait_cnt;
  logic                                   active;
  logic [NUM_REQ-1:0]                     starving;
  logic [NUM_REQ-1:0]                     grant_p0;
  logic [CDB_WIDTH-1:0]                   vld_p0;
  logic [CDB_WIDTH-1:0][PTR_W-1:0]        src_p0;
  logic [PTR_W-1:0]                       rr_nxt_p0;

  logic [CDB_WIDTH-1:0]                   vld_p1;
  logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0]    prf_p1;
  logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0]    rob_p1;
  logic [CDB_WIDTH-1:0][XLEN-1:0]         value_p1;
  logic [CDB_WIDTH-1:0]                   rw_p1;

  // Stage p0: combinational two-tier selection and slot packing
  assign active = reset & ~flush;

  always_comb begin
    starving = '0;
    for (int i = 0; i < NUM_REQ; i++)
      starving[i] = req_valid[i] && (wait_cnt[i] == CNT_MAX);
  end

  always_comb begin
    int n;
    int idx;
    n         = 0;
    idx       = 0;
    grant_p0  = '0;
    vld_p0    = '0;
    src_p0    = '0;
    rr_nxt_p0 = rr_ptr;
    if (active) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (starving[i] && n < CDB_WIDTH) begin
          grant_p0[i] = 1'b1;
          vld_p0[n]   = 1'b1;
          src_p0[n]   = PTR_W'(i);
          rr_nxt_p0   = ptr_inc(PTR_W'(i));
          n           = n + 1;
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (req_valid[idx] && !starving[idx] && n < CDB_WIDTH) begin
          grant_p0[idx] = 1'b1;
          vld_p0[n]     = 1'b1;
          src_p0[n]     = PTR_W'(idx);
          rr_nxt_p0     = ptr_inc(PTR_W'(idx));
          n             = n + 1;
        end
      end
    end
  end

  assign grant      = grant_p0;
  assign CDB_hazard = active ? (req_valid & ~grant_p0) : '0;

  // Stage p1: registered broadcast slots
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1   <= '0;
      prf_p1   <= '0;
      rob_p1   <= '0;
      value_p1 <= '0;
      rw_p1    <= '0;
    end else begin
      vld_p1 <= vld_p0;
      for (int s = 0; s < CDB_WIDTH; s++) begin
        if (vld_p0[s]) begin
          prf_p1[s]   <= req_prf_idx[src_p0[s]];
          rob_p1[s]   <= req_rob_idx[src_p0[s]];
          value_p1[s] <= req_value[src_p0[s]];
          rw_p1[s]    <= req_reg_write[src_p0[s]];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      wait_cnt <= '0;
    end else if (flush) begin
      wait_cnt <= '0;
    end else begin
      if (|grant_p0) rr_ptr <= rr_nxt_p0;
      for (int i = 0; i < NUM_REQ; i++)
        wait_cnt[i] <= (req_valid[i] && !grant_p0[i]) ? sat_inc(wait_cnt[i]) : '0;
    end
  end

  assign cdb_valid     = vld_p1;
  assign cdb_prf_idx   = prf_p1;
  assign cdb_rob_idx   = rob_p1;
  assign cdb_value     = value_p1;
  assign cdb_reg_write = rw_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus a randomized run
// against an independent priority-key model; a second instance uses STARVE_LIMIT=1.
module tb_cdb_arbiter;

  logic             clock;
  logic             reset;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][5:0]  req_prf_idx;
  logic [3:0][4:0]  req_rob_idx;
  logic [3:0][31:0] req_value;
  logic [3:0]       req_reg_write;

  logic [3:0]       grant, cdb_hazard;
  logic [1:0]       cdb_valid, cdb_reg_write;
  logic [1:0][5:0]  cdb_prf_idx;
  logic [1:0][4:0]  cdb_rob_idx;
  logic [1:0][31:0] cdb_value;

  logic [3:0]       sv_grant, sv_hazard;
  logic [1:0]       sv_valid, sv_reg_write;
  logic [1:0][5:0]  sv_prf_idx;
  logic [1:0][4:0]  sv_rob_idx;
  logic [1:0][31:0] sv_value;

  typedef struct packed {
    logic [1:0]       vld;
    logic [1:0][43:0] p;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_prf_idx(req_prf_idx), .req_rob_idx(req_rob_idx),
    .req_value(req_value), .req_reg_write(req_reg_write),
    .grant(grant), .CDB_hazard(cdb_hazard), .cdb_valid(cdb_valid),
    .cdb_prf_idx(cdb_prf_idx), .cdb_rob_idx(cdb_rob_idx),
    .cdb_value(cdb_value), .cdb_reg_write(cdb_reg_write)
  );

  cdb_arbiter #(.STARVE_LIMIT(1)) u_sv (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_prf_idx(req_prf_idx), .req_rob_idx(req_rob_idx),
    .req_value(req_value), .req_reg_write(req_reg_write),
    .grant(sv_grant), .CDB_hazard(sv_hazard), .cdb_valid(sv_valid),
    .cdb_prf_idx(sv_prf_idx), .cdb_rob_idx(sv_rob_idx),
    .cdb_value(sv_value), .cdb_reg_write(sv_reg_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [43:0] pay(input int i);
    return {req_value[i], req_prf_idx[i], req_rob_idx[i], req_reg_write[i]};
  endfunction

  function automatic logic [43:0] out_pay(input int s);
    return {cdb_value[s], cdb_prf_idx[s], cdb_rob_idx[s], cdb_reg_write[s]};
  endfunction

  function automatic logic [43:0] sv_pay(input int s);
    return {sv_value[s], sv_prf_idx[s], sv_rob_idx[s], sv_reg_write[s]};
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic set_payload();
    for (int i = 0; i < 4; i++) begin
      req_value[i]     = $urandom;
      req_prf_idx[i]   = 6'($urandom);
      req_rob_idx[i]   = 5'($urandom);
      req_reg_write[i] = 1'($urandom);
    end
  endtask

  task automatic push_exp(input logic [1:0] vld, input int s0, input int s1);
    exp_t e;
    e.vld  = vld;
    e.p[0] = pay(s0);
    e.p[1] = pay(s1);
    sb_q.push_back(e);
  endtask

  task automatic pulse_reset();
    next_cycle();
    reset     = 1'b0;
    flush     = 1'b0;
    req_valid = 4'b0000;
    sb_q.delete();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (cdb_valid !== e.vld) begin
          errors++;
          $display("FAIL sb_cdb_valid t=%0t got %b exp %b", $time, cdb_valid, e.vld);
        end
        for (int s = 0; s < 2; s++) begin
          if (e.vld[s]) begin
            checks++;
            if (out_pay(s) !== e.p[s]) begin
              errors++;
              $display("FAIL sb_slot%0d_payload t=%0t got %h exp %h", s, $time, out_pay(s), e.p[s]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    reset     = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (grant !== 4'b0000 || cdb_hazard !== 4'b0000 || sv_grant !== 4'b0000) begin
      errors++;
      $display("FAIL reset_grant got %b/%b exp 0000/0000", grant, cdb_hazard);
    end
    #10;
    checks++;
    if ({cdb_valid, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_reg_write} !== '0) begin
      errors++;
      $display("FAIL reset_cdb got valid=%b value=%h exp all zero", cdb_valid, cdb_value);
    end
    @(negedge clock);
    reset     = 1'b1;
    req_valid = 4'b0000;
  endtask

  task automatic test_two_req();
    next_cycle();
    set_payload();
    req_value[0] = 32'h11;
    req_value[1] = 32'h22;
    req_valid    = 4'b0011;
    #2;
    checks++;
    if (grant !== 4'b0011 || cdb_hazard !== 4'b0000) begin
      errors++;
      $display("FAIL two_req got %b/%b exp 0011/0000", grant, cdb_hazard);
    end
    push_exp(2'b11, 0, 1);
    next_cycle();
    set_payload();
    req_valid = 4'b0111;
    #2;
    checks++;
    if (grant !== 4'b0101 || cdb_hazard !== 4'b0010) begin
      errors++;
      $display("FAIL two_req_rr2 got %b/%b exp 0101/0010", grant, cdb_hazard);
    end
    push_exp(2'b11, 2, 0);
  endtask

  task automatic test_empty();
    next_cycle();
    set_payload();
    req_valid = 4'b0000;
    #2;
    checks++;
    if (grant !== 4'b0000 || cdb_hazard !== 4'b0000) begin
      errors++;
      $display("FAIL empty got %b/%b exp 0000/0000", grant, cdb_hazard);
    end
    push_exp(2'b00, 0, 0);
    next_cycle();
    set_payload();
    req_valid = 4'b1111;
    #2;
    checks++;
    if (grant !== 4'b0110 || cdb_hazard !== 4'b1001) begin
      errors++;
      $display("FAIL empty_rr_hold got %b/%b exp 0110/1001", grant, cdb_hazard);
    end
    push_exp(2'b11, 1, 2);
  endtask

  task automatic test_flush();
    next_cycle();
    set_payload();
    req_valid = 4'b1111;
    #2;
    checks++;
    if (grant !== 4'b1001 || cdb_hazard !== 4'b0110) begin
      errors++;
      $display("FAIL pre_flush got %b/%b exp 1001/0110", grant, cdb_hazard);
    end
    push_exp(2'b11, 3, 0);
    next_cycle();
    set_payload();
    flush = 1'b1;
    #2;
    checks++;
    if (grant !== 4'b0000 || cdb_hazard !== 4'b0000) begin
      errors++;
      $display("FAIL flush got %b/%b exp 0000/0000", grant, cdb_hazard);
    end
    push_exp(2'b00, 0, 0);
    next_cycle();
    set_payload();
    flush = 1'b0;
    #2;
    checks++;
    if (grant !== 4'b0110 || cdb_hazard !== 4'b1001) begin
      errors++;
      $display("FAIL post_flush_rr got %b/%b exp 0110/1001", grant, cdb_hazard);
    end
    push_exp(2'b11, 1, 2);
  endtask

  task automatic test_back_to_back();
    logic [3:0] eg [3];
    int         s0 [3];
    eg = '{4'b0011, 4'b1100, 4'b0011};
    s0 = '{0, 2, 0};
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      set_payload();
      if (c == 0) req_reg_write = 4'b0101;
      req_valid = 4'b1111;
      #2;
      checks++;
      if (grant !== eg[c] || cdb_hazard !== ~eg[c]) begin
        errors++;
        $display("FAIL b2b_cycle%0d got %b/%b exp %b/%b", c, grant, cdb_hazard, eg[c], ~eg[c]);
      end
      push_exp(2'b11, s0[c], s0[c] + 1);
    end
  endtask

  task automatic test_starvation();
    logic [87:0] sv_exp;
    pulse_reset();
    next_cycle();
    set_payload();
    req_valid = 4'b1011;
    #2;
    checks++;
    if (grant !== 4'b0011 || sv_grant !== 4'b0011 || sv_hazard !== 4'b1000) begin
      errors++;
      $display("FAIL starve_c0 got %b/%b/%b exp 0011/0011/1000", grant, sv_grant, sv_hazard);
    end
    push_exp(2'b11, 0, 1);
    next_cycle();
    set_payload();
    req_valid = 4'b1111;
    #2;
    checks++;
    if (grant !== 4'b1100 || sv_grant !== 4'b1100 || sv_hazard !== 4'b0011) begin
      errors++;
      $display("FAIL starve_c1 got %b/%b/%b exp 1100/1100/0011", grant, sv_grant, sv_hazard);
    end
    push_exp(2'b11, 2, 3);
    sv_exp = {pay(3), pay(2)};
    next_cycle();
    checks++;
    if (sv_valid !== 2'b11 || {sv_pay(0), sv_pay(1)} !== sv_exp) begin
      errors++;
      $display("FAIL starve_slot_order got %b %h exp 11 %h", sv_valid, {sv_pay(0), sv_pay(1)}, sv_exp);
    end
    set_payload();
    #2;
    checks++;
    if (grant !== 4'b0011 || sv_grant !== 4'b0011 || sv_hazard !== 4'b1100) begin
      errors++;
      $display("FAIL starve_c2 got %b/%b/%b exp 0011/0011/1100", grant, sv_grant, sv_hazard);
    end
    push_exp(2'b11, 0, 1);
    sv_exp = {pay(0), pay(1)};
    next_cycle();
    checks++;
    if (sv_valid !== 2'b11 || {sv_pay(0), sv_pay(1)} !== sv_exp) begin
      errors++;
      $display("FAIL starve_c2_slots got %b %h exp 11 %h", sv_valid, {sv_pay(0), sv_pay(1)}, sv_exp);
    end
    set_payload();
    req_valid = 4'b0000;
    #2;
    push_exp(2'b00, 0, 0);
  endtask

  task automatic test_reset_midrun();
    next_cycle();
    set_payload();
    req_valid = 4'b1111;
    #2;
    checks++;
    if (grant !== 4'b1100) begin
      errors++;
      $display("FAIL midrun_pre got %b exp 1100", grant);
    end
    push_exp(2'b11, 2, 3);
    next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || cdb_value !== '0 || grant !== 4'b0000 || cdb_hazard !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_reset got valid=%b grant=%b hazard=%b exp 00/0000/0000", cdb_valid, grant, cdb_hazard);
    end
    @(negedge clock);
    reset     = 1'b1;
    req_valid = 4'b0000;
    next_cycle();
    set_payload();
    req_valid = 4'b0100;
    #2;
    checks++;
    if (grant !== 4'b0100 || cdb_hazard !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_after got %b/%b exp 0100/0000", grant, cdb_hazard);
    end
    push_exp(2'b01, 2, 0);
    next_cycle();
    set_payload();
    req_valid = 4'b1111;
    #2;
    checks++;
    if (grant !== 4'b1001) begin
      errors++;
      $display("FAIL midrun_rr got %b exp 1001", grant);
    end
    push_exp(2'b11, 3, 0);
  endtask

  task automatic test_random();
    int         m_rr;
    int         m_wait [4];
    int         key [4];
    int         w0, w1;
    logic [3:0] v, eg, eh;
    logic       fl;
    pulse_reset();
    m_rr   = 0;
    m_wait = '{0, 0, 0, 0};
    for (int c = 0; c < 200; c++) begin
      next_cycle();
      v  = 4'($urandom);
      fl = ($urandom_range(0, 7) == 0);
      set_payload();
      req_valid = v;
      flush     = fl;
      #2;
      for (int i = 0; i < 4; i++)
        key[i] = !v[i] ? 99 : (m_wait[i] == 3) ? i : 4 + ((i - m_rr + 4) % 4);
      w0 = -1;
      w1 = -1;
      if (!fl) begin
        for (int i = 0; i < 4; i++) begin
          if (key[i] < 99) begin
            if (w0 < 0 || key[i] < key[w0]) begin
              w1 = w0;
              w0 = i;
            end else if (w1 < 0 || key[i] < key[w1]) begin
              w1 = i;
            end
          end
        end
      end
      eg = '0;
      if (w0 >= 0) eg[w0] = 1'b1;
      if (w1 >= 0) eg[w1] = 1'b1;
      eh = fl ? 4'b0000 : (v & ~eg);
      checks++;
      if (grant !== eg || cdb_hazard !== eh) begin
        errors++;
        $display("FAIL rand_c%0d v=%b fl=%b got %b/%b exp %b/%b", c, v, fl, grant, cdb_hazard, eg, eh);
      end
      push_exp({w1 >= 0, w0 >= 0}, (w0 < 0) ? 0 : w0, (w1 < 0) ? 0 : w1);
      for (int i = 0; i < 4; i++)
        m_wait[i] = (fl || !v[i] || eg[i]) ? 0 : ((m_wait[i] < 3) ? m_wait[i] + 1 : 3);
      if (w1 >= 0) m_rr = (w1 + 1) % 4;
      else if (w0 >= 0) m_rr = (w0 + 1) % 4;
    end
    flush = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 4'b0000;
    set_payload();
    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_two_req();
    test_empty();
    test_flush();
    test_back_to_back();
    test_starvation();
    test_reset_midrun();
    test_random();
    next_cycle();
    req_valid = 4'b0000;
    next_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d entries exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
